// File: rtl/yantar_wb_collect.sv
// Writeback collector for the yantar integer core: per-source result FIFOs drained round-robin
// onto the four register-file write ports, plus same-cycle ALU forwarding lanes.
module yantar_wb_collect #(
    parameter int unsigned NSRC  = 6,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 65
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stall,
    input  logic [NSRC-1:0]    src_valid,
    output logic [NSRC-1:0]    src_ready,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic [NSRC*DW-1:0] src_data,
    input  logic [AW-1:0]      read0_addr,
    input  logic [AW-1:0]      read1_addr,
    input  logic [AW-1:0]      read2_addr,
    input  logic [AW-1:0]      read3_addr,
    output logic [AW-1:0]      write0_addr,
    output logic [AW-1:0]      write1_addr,
    output logic [AW-1:0]      write2_addr,
    output logic [AW-1:0]      write3_addr,
    output logic [DW-1:0]      write0_data,
    output logic [DW-1:0]      write1_data,
    output logic [DW-1:0]      write2_data,
    output logic [DW-1:0]      write3_data,
    output logic               write0_wen,
    output logic               write1_wen,
    output logic               write2_wen,
    output logic               write3_wen,
    output logic [DW-1:0]      fwd_dataA,
    output logic [1:0]         fwd_enA,
    output logic [DW-1:0]      fwd_dataB,
    output logic [1:0]         fwd_enB,
    output logic               busy
);
    localparam int unsigned NP = 4;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned GW = $clog2(NP + 1);

    logic [AW-1:0]   mem_addr_q [NSRC][DEPTH];
    logic [DW-1:0]   mem_data_q [NSRC][DEPTH];
    logic [PW-1:0]   rd_ptr_q [NSRC];
    logic [PW-1:0]   rd_ptr_d [NSRC];
    logic [PW-1:0]   wr_ptr_q [NSRC];
    logic [PW-1:0]   wr_ptr_d [NSRC];
    logic [CW-1:0]   cnt_q [NSRC];
    logic [CW-1:0]   cnt_d [NSRC];
    logic [SW-1:0]   rr_q, rr_d;
    logic [NSRC-1:0] push, grant;
    logic [AW-1:0]   head_addr [NSRC];
    logic [DW-1:0]   head_data [NSRC];

    logic [NP-1:0]   port_vld, wen_q;
    logic [AW-1:0]   port_addr [NP];
    logic [AW-1:0]   waddr_q [NP];
    logic [DW-1:0]   port_data [NP];
    logic [DW-1:0]   wdata_q [NP];
    logic [GW-1:0]   ngrant;
    logic [SW-1:0]   sel, last;
    logic            hit;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_ready[i] = (cnt_q[i] < CW'(DEPTH)) && !flush;
            head_addr[i] = mem_addr_q[i][rd_ptr_q[i]];
            head_data[i] = mem_data_q[i][rd_ptr_q[i]];
        end
    end

    assign push = src_valid & src_ready;

    // Grants fill write ports in scan order; a head matching an earlier grant's address waits.
    always_comb begin
        grant    = '0;
        port_vld = '0;
        ngrant   = '0;
        sel      = '0;
        hit      = 1'b0;
        last     = rr_q;
        for (int k = 0; k < NP; k++) begin
            port_addr[k] = '0;
            port_data[k] = '0;
        end
        for (int j = 0; j < NSRC; j++) begin
            sel = SW'((int'(rr_q) + j) % int'(NSRC));
            hit = 1'b0;
            for (int k = 0; k < NP; k++) begin
                if (port_vld[k] && port_addr[k] == head_addr[sel]) hit = 1'b1;
            end
            if (cnt_q[sel] != '0 && ngrant < GW'(NP) && !hit) begin
                grant[sel]                = 1'b1;
                port_vld[ngrant[1:0]]     = 1'b1;
                port_addr[ngrant[1:0]]    = head_addr[sel];
                port_data[ngrant[1:0]]    = head_data[sel];
                ngrant                    = ngrant + GW'(1);
                last                      = sel;
            end
        end
        rr_d = rr_q;
        if (port_vld[0]) rr_d = (last == SW'(NSRC - 1)) ? '0 : last + SW'(1);
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            rd_ptr_d[i] = rd_ptr_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (push[i]) wr_ptr_d[i] = (wr_ptr_q[i] == PW'(DEPTH - 1)) ? '0 : wr_ptr_q[i] + PW'(1);
            if (grant[i]) rd_ptr_d[i] = (rd_ptr_q[i] == PW'(DEPTH - 1)) ? '0 : rd_ptr_q[i] + PW'(1);
            if (push[i] && !grant[i]) cnt_d[i] = cnt_q[i] + CW'(1);
            else if (!push[i] && grant[i]) cnt_d[i] = cnt_q[i] - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_addr_q[i][e] <= '0;
                    mem_data_q[i][e] <= '0;
                end
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            for (int k = 0; k < NP; k++) begin
                waddr_q[k] <= '0;
                wdata_q[k] <= '0;
            end
            wen_q <= '0;
            rr_q  <= '0;
        end else if (flush) begin
            for (int i = 0; i < NSRC; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            wen_q <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    mem_addr_q[i][wr_ptr_q[i]] <= src_addr[i*AW +: AW];
                    mem_data_q[i][wr_ptr_q[i]] <= src_data[i*DW +: DW];
                end
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            for (int k = 0; k < NP; k++) begin
                if (port_vld[k]) begin
                    waddr_q[k] <= port_addr[k];
                    wdata_q[k] <= port_data[k];
                end
            end
            wen_q <= port_vld;
            rr_q  <= rr_d;
        end
    end

    assign write0_addr = waddr_q[0];
    assign write1_addr = waddr_q[1];
    assign write2_addr = waddr_q[2];
    assign write3_addr = waddr_q[3];
    assign write0_data = wdata_q[0];
    assign write1_data = wdata_q[1];
    assign write2_data = wdata_q[2];
    assign write3_data = wdata_q[3];
    assign write0_wen  = wen_q[0];
    assign write1_wen  = wen_q[1];
    assign write2_wen  = wen_q[2];
    assign write3_wen  = wen_q[3];

    always_comb begin
        busy = |wen_q;
        for (int i = 0; i < NSRC; i++) begin
            if (cnt_q[i] != '0) busy = 1'b1;
        end
    end

    // Forwarding looks only at the live ALU inputs, never at queued state.
    assign fwd_dataA  = src_data[DW-1:0];
    assign fwd_dataB  = src_data[2*DW-1:DW];
    assign fwd_enA[0] = src_valid[0] && (src_addr[AW-1:0] == read0_addr) && !stall;
    assign fwd_enA[1] = src_valid[0] && (src_addr[AW-1:0] == read1_addr) && !stall;
    assign fwd_enB[0] = src_valid[1] && (src_addr[2*AW-1:AW] == read2_addr) && !stall;
    assign fwd_enB[1] = src_valid[1] && (src_addr[2*AW-1:AW] == read3_addr) && !stall;

endmodule
